sigmoid_lut_arbiter: RTL and testbench

Shares one sigmoid lookup ROM (registered address, combinational data) among `numReq` neuron requesters. Each neuron presents its pre-activation value through a valid/ready handshake. A round-robin scheduler grants at most one lookup per cycle, and the result returns to the winner on a shared result bus tagged by a one-hot valid. The block sits between the neuron array and the single activation ROM in each layer.

---
 rtl/nn_pkg.sv | 18 +
 rtl/rr_arbiter.sv | 34 +++
 rtl/sigmoid_lut_arbiter.sv | 120 ++++++++++++
 tb/tb_sigmoid_lut_arbiter.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/nn_pkg.sv
// Shared definitions for the neuron-array activation blocks: one-hot helper,
// default requester count with its pointer width, and the statistics counter width.
package nn_pkg;

  localparam int unsigned NUM_REQ  = 4;
  localparam int unsigned RR_PTR_W = $clog2(NUM_REQ);
  localparam int unsigned STAT_W   = 16;
  localparam int unsigned MAX_REQ  = 16;

  // Out-of-range ids yield an all-zero vector rather than aliasing onto a low bit.
  function automatic logic [MAX_REQ-1:0] onehot(input int unsigned id, input int unsigned n);
    logic [MAX_REQ-1:0] v;
    v = '0;
    if (id < n && id < MAX_REQ) v[id[3:0]] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request at or above ptr_i (with wrap).
// Zero latency; grants nothing while en_i is low.
module rr_arbiter #(
  parameter int unsigned N  = 4,
  parameter int unsigned PW = 2
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  input  logic          en_i,
  output logic [N-1:0]  gnt_o,
  output logic [PW-1:0] idx_o,
  output logic          vld_o
);

  logic [PW-1:0] cand;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    vld_o = 1'b0;
    cand  = '0;
    if (en_i) begin
      for (int k = 0; k < int'(N); k++) begin
        cand = PW'((int'(ptr_i) + k) % int'(N));
        if (!vld_o && req_i[cand]) begin
          vld_o = 1'b1;
          idx_o = cand;
        end
      end
      if (vld_o) gnt_o[idx_o] = 1'b1;
    end
  end

endmodule

// File: rtl/sigmoid_lut_arbiter.sv
// Shares one registered-address sigmoid ROM among numReq neurons; results return 2 edges after accept.
// Optional saturating grant/stall counters are built when SIGMOID_ARB_STATS_EN is defined.
module sigmoid_lut_arbiter
  import nn_pkg::*;
#(
  parameter int unsigned numReq    = 4,
  parameter int unsigned inWidth   = 10,
  parameter int unsigned dataWidth = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic [numReq-1:0]         req_valid,
  input  logic [numReq*inWidth-1:0] req_x,
  output logic [numReq-1:0]         req_ready,
  output logic [inWidth-1:0]        rom_x,
  input  logic [dataWidth-1:0]      rom_out,
  output logic [numReq-1:0]         res_valid,
  output logic [dataWidth-1:0]      res_data,
  output logic                      busy
`ifdef SIGMOID_ARB_STATS_EN
  ,
  output logic [numReq*STAT_W-1:0]  stat_grants,
  output logic [STAT_W-1:0]         stat_stall
`endif
);

  localparam int unsigned PtrW = (numReq > 1) ? $clog2(numReq) : 1;

  logic [PtrW-1:0]      rr_ptr_q, rr_ptr_d;
  logic [PtrW-1:0]      win_idx;
  logic                 win_vld;
  logic [inWidth-1:0]   win_x;
  logic [inWidth-1:0]   rom_x_q;
  logic                 t1_valid_q;
  logic [PtrW-1:0]      t1_id_q, t1_id_d;
  logic [numReq-1:0]    res_valid_q, res_valid_d;
  logic [dataWidth-1:0] res_data_q, res_data_d;

  rr_arbiter #(.N(numReq), .PW(PtrW)) u_arb (
    .req_i (req_valid),
    .ptr_i (rr_ptr_q),
    .en_i  (en),
    .gnt_o (req_ready),
    .idx_o (win_idx),
    .vld_o (win_vld)
  );

  always_comb begin
    win_x = '0;
    for (int i = 0; i < int'(numReq); i++) begin
      if (req_ready[i]) win_x = req_x[i*inWidth +: inWidth];
    end
  end

  // The ROM samples rom_x every edge, so an idle cycle must keep presenting the last address.
  assign rom_x = win_vld ? win_x : rom_x_q;

  always_comb begin
    rr_ptr_d    = rr_ptr_q;
    t1_id_d     = t1_id_q;
    res_valid_d = '0;
    res_data_d  = res_data_q;
    if (win_vld) begin
      rr_ptr_d = (win_idx == PtrW'(numReq - 1)) ? '0 : win_idx + PtrW'(1);
      t1_id_d  = win_idx;
    end
    if (t1_valid_q) begin
      res_valid_d = numReq'(onehot(32'(t1_id_q), numReq));
      res_data_d  = rom_out;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_q    <= '0;
      rom_x_q     <= '0;
      t1_valid_q  <= 1'b0;
      t1_id_q     <= '0;
      res_valid_q <= '0;
      res_data_q  <= '0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      rom_x_q     <= rom_x;
      t1_valid_q  <= win_vld;
      t1_id_q     <= t1_id_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
    end
  end

  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign busy      = t1_valid_q | (|res_valid_q);

`ifdef SIGMOID_ARB_STATS_EN
  logic [STAT_W-1:0] grant_cnt_q [numReq];
  logic [STAT_W-1:0] stall_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(numReq); i++) grant_cnt_q[i] <= '0;
      stall_cnt_q <= '0;
    end else begin
      for (int i = 0; i < int'(numReq); i++) begin
        if (req_ready[i] && grant_cnt_q[i] != '1) grant_cnt_q[i] <= grant_cnt_q[i] + STAT_W'(1);
      end
      if ((|req_valid) && !en && stall_cnt_q != '1) stall_cnt_q <= stall_cnt_q + STAT_W'(1);
    end
  end

  always_comb begin
    stat_grants = '0;
    for (int i = 0; i < int'(numReq); i++) stat_grants[i*STAT_W +: STAT_W] = grant_cnt_q[i];
  end

  assign stat_stall = stall_cnt_q;
`endif

endmodule

// File: tb/tb_sigmoid_lut_arbiter.sv
// Directed bench: per-cycle vector table from reset, then en-low, mid-flight reset and counter saturation sequences.
module tb_sigmoid_lut_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [3:0]  req_valid;
  logic [39:0] req_x;
  logic [3:0]  req_ready;
  logic [9:0]  rom_x;
  logic [15:0] rom_out;
  logic [3:0]  res_valid;
  logic [15:0] res_data;
  logic        busy;
`ifdef SIGMOID_ARB_STATS_EN
  logic [63:0] stat_grants;
  logic [15:0] stat_stall;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  sigmoid_lut_arbiter #(.numReq(4), .inWidth(10), .dataWidth(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .req_valid  (req_valid),
    .req_x      (req_x),
    .req_ready  (req_ready),
    .rom_x      (rom_x),
    .rom_out    (rom_out),
    .res_valid  (res_valid),
    .res_data   (res_data),
    .busy       (busy)
`ifdef SIGMOID_ARB_STATS_EN
    ,
    .stat_grants(stat_grants),
    .stat_stall (stat_stall)
`endif
  );

  // ROM model: registered address, data = x + 0x100.
  logic [9:0] rom_addr_q = '0;
  always @(posedge clk) rom_addr_q <= rom_x;
  assign rom_out = {6'd0, rom_addr_q} + 16'h0100;

  typedef struct {
    logic        en;
    logic [3:0]  vld;
    logic [39:0] x;
    logic [3:0]  rdy;
    logic [3:0]  rv;
    logic [15:0] rd;
    logic        bsy;
  } vec_t;

  vec_t tbl [16];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    next_cycle();
    next_cycle();
    rst = 1'b0;
  endtask

  initial begin
    logic [39:0] x2, xi;
    x2 = {10'd0, 10'd5, 10'd0, 10'd0};
    xi = {10'd3, 10'd2, 10'd1, 10'd0};
    //              en    vld      x   rdy      rv       rd        bsy
    tbl[0]  = '{1'b1, 4'b0100, x2, 4'b0100, 4'b0000, 16'h0000, 1'b0};
    tbl[1]  = '{1'b1, 4'b0000, x2, 4'b0000, 4'b0000, 16'h0000, 1'b1};
    tbl[2]  = '{1'b1, 4'b0000, x2, 4'b0000, 4'b0100, 16'h0105, 1'b1};
    tbl[3]  = '{1'b1, 4'b1111, xi, 4'b1000, 4'b0000, 16'h0000, 1'b0};
    tbl[4]  = '{1'b1, 4'b1111, xi, 4'b0001, 4'b0000, 16'h0000, 1'b1};
    tbl[5]  = '{1'b1, 4'b1111, xi, 4'b0010, 4'b1000, 16'h0103, 1'b1};
    tbl[6]  = '{1'b1, 4'b1111, xi, 4'b0100, 4'b0001, 16'h0100, 1'b1};
    tbl[7]  = '{1'b1, 4'b1111, xi, 4'b1000, 4'b0010, 16'h0101, 1'b1};
    tbl[8]  = '{1'b1, 4'b1111, xi, 4'b0001, 4'b0100, 16'h0102, 1'b1};
    tbl[9]  = '{1'b1, 4'b0000, xi, 4'b0000, 4'b1000, 16'h0103, 1'b1};
    tbl[10] = '{1'b1, 4'b0010, xi, 4'b0010, 4'b0001, 16'h0100, 1'b1};
    tbl[11] = '{1'b1, 4'b1010, xi, 4'b1000, 4'b0000, 16'h0000, 1'b1};
    tbl[12] = '{1'b1, 4'b1010, xi, 4'b0010, 4'b0010, 16'h0101, 1'b1};
    tbl[13] = '{1'b1, 4'b0000, xi, 4'b0000, 4'b1000, 16'h0103, 1'b1};
    tbl[14] = '{1'b0, 4'b0001, xi, 4'b0000, 4'b0010, 16'h0101, 1'b1};
    tbl[15] = '{1'b0, 4'b0001, xi, 4'b0000, 4'b0000, 16'h0000, 1'b0};

    rst = 1'b1; en = 1'b0; req_valid = '0; req_x = '0;
    next_cycle();
    check("reset res_valid", 32'(res_valid), 32'h0);
    check("reset res_data", 32'(res_data), 32'h0);
    check("reset busy", 32'(busy), 32'h0);
`ifdef SIGMOID_ARB_STATS_EN
    check("reset stat_stall", 32'(stat_stall), 32'h0);
`endif
    next_cycle();
    rst = 1'b0;

    for (int i = 0; i < 16; i++) begin
      en = tbl[i].en; req_valid = tbl[i].vld; req_x = tbl[i].x;
      #1;
      check($sformatf("v%0d req_ready", i), 32'(req_ready), 32'(tbl[i].rdy));
      check($sformatf("v%0d res_valid", i), 32'(res_valid), 32'(tbl[i].rv));
      check($sformatf("v%0d busy", i), 32'(busy), 32'(tbl[i].bsy));
      if (tbl[i].rv != 4'b0000)
        check($sformatf("v%0d res_data", i), 32'(res_data), 32'(tbl[i].rd));
      next_cycle();
    end

    // Accept just before en falls; the lookup still completes while grants are blocked.
    req_valid = '0; en = 1'b1;
    do_reset();
    req_valid = 4'b0001; req_x = {30'd0, 10'd7};
    #1;
    check("en accept ready", 32'(req_ready), 32'h1);
    next_cycle();
    en = 1'b0;
    for (int c = 0; c < 5; c++) begin
      #1;
      check($sformatf("en low c%0d ready", c), 32'(req_ready), 32'h0);
      if (c == 1) begin
        check("en low res_valid", 32'(res_valid), 32'h1);
        check("en low res_data", 32'(res_data), 32'h0107);
      end
      next_cycle();
    end
    en = 1'b1; req_valid = '0;
    #1;
    check("en low done busy", 32'(busy), 32'h0);
`ifdef SIGMOID_ARB_STATS_EN
    check("stat_stall", 32'(stat_stall), 32'd5);
    check("stat_grants0", 32'(stat_grants[15:0]), 32'd1);
`endif

    // Reset one cycle after an accept drops the in-flight tag and the pointer.
    do_reset();
    req_valid = 4'b0100; req_x = {10'd0, 10'd9, 20'd0};
    #1;
    check("rst seq ready", 32'(req_ready), 32'h4);
    next_cycle();
    req_valid = '0;
    #1;
    check("rst seq inflight busy", 32'(busy), 32'h1);
    rst = 1'b1;
    #1;
    check("rst async busy", 32'(busy), 32'h0);
    next_cycle();
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      check($sformatf("rst seq c%0d res_valid", c), 32'(res_valid), 32'h0);
      next_cycle();
    end
    req_valid = 4'b1010;
    #1;
    check("rst seq grant lowest", 32'(req_ready), 32'h2);
    next_cycle();
    req_valid = '0;

`ifdef SIGMOID_ARB_STATS_EN
    do_reset();
    req_valid = 4'b0010;
    repeat (70000) @(posedge clk);
    #1;
    check("stat_grants1 sat", 32'(stat_grants[31:16]), 32'h0000FFFF);
    check("stat_grants0 clr", 32'(stat_grants[15:0]), 32'h0);
    req_valid = '0;
`endif

    next_cycle();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
